// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, issues one word read per instruction and presents it to decode.
// Optional misaligned-PC fault detection is enabled by defining IFU_ALIGN_CHECK_EN.

`ifndef RISCV_XLEN
`define RISCV_XLEN 32
`endif

module inst_fetch #(
  parameter logic [`RISCV_XLEN-1:0] RESET_PC = `RISCV_XLEN'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [`RISCV_XLEN-1:0] imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  input  logic                   imem_rsp_err,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_inst,
  output logic [`RISCV_XLEN-1:0] id_pc,
  output logic                   id_fault,
  input  logic                   redirect_valid,
  input  logic [`RISCV_XLEN-1:0] redirect_pc
);

  localparam int unsigned XLEN = `RISCV_XLEN;

  typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic            misaligned;

`ifdef IFU_ALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      StBoot: begin
        state_d = StReq;
        if (redirect_valid) pc_d = redirect_pc;
      end
      StReq: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // The accepted request targets the old PC, so its response must be thrown away.
          if (!misaligned && imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = StWait;
          end
        end else if (misaligned) begin
          inst_d  = 32'h0;
          fault_d = 1'b1;
          state_d = StHold;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d  = imem_rsp_err ? 32'h0 : imem_rsp_data;
            fault_d = imem_rsp_err;
            state_d = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (id_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = StReq;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == StReq) && !misaligned;
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign id_valid       = (state_q == StHold);
  assign id_pc          = pc_q;
  assign id_inst        = inst_q;
  assign id_fault       = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written redirect/wrap sequences, and
// randomized traffic checked against a PC-stream model of the fetch unit.

`ifndef RISCV_XLEN
`define RISCV_XLEN 32
`endif

module tb_inst_fetch;

  localparam int unsigned XLEN = `RISCV_XLEN;
  localparam logic [XLEN-1:0] RST_PC = XLEN'(32'h8000_0000);

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_fault       (id_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // Memory contents and fault map are pure functions of the word address.
  function automatic logic [31:0] mdata(input logic [XLEN-1:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic merr(input logic [XLEN-1:0] a);
    return a[6:2] == 5'h13;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  typedef struct {
    int              rdy_dly;
    int              rsp_dly;
    int              dec_dly;
    logic            err;
    logic [XLEN-1:0] pc;
  } vec_t;

  vec_t vt[7];

  // One full fetch starting in REQ: request stall, response delay, decode stall.
  task automatic run_vec(input vec_t v);
    logic [31:0] ei;
    ei = v.err ? 32'h0 : mdata(v.pc);
    for (int i = 0; i < v.rdy_dly; i++) begin
      chk("stall_req_valid", 64'(imem_req_valid), 64'(1));
      chk("stall_req_addr", 64'(imem_req_addr), 64'(v.pc));
      chk("stall_id_valid", 64'(id_valid), 64'(0));
      step;
    end
    chk("req_valid", 64'(imem_req_valid), 64'(1));
    chk("req_addr", 64'(imem_req_addr), 64'(v.pc));
    imem_req_ready = 1'b1;
    step;
    imem_req_ready = 1'b0;
    for (int i = 0; i < v.rsp_dly; i++) begin
      chk("wait_id_valid", 64'(id_valid), 64'(0));
      chk("wait_req_valid", 64'(imem_req_valid), 64'(0));
      step;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mdata(v.pc);
    imem_rsp_err   = v.err;
    step;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    for (int i = 0; i <= v.dec_dly; i++) begin
      chk("hold_id_valid", 64'(id_valid), 64'(1));
      chk("hold_id_pc", 64'(id_pc), 64'(v.pc));
      chk("hold_id_inst", 64'(id_inst), 64'(ei));
      chk("hold_id_fault", 64'(id_fault), 64'(v.err));
      if (i < v.dec_dly) step;
    end
    id_ready = 1'b1;
    step;
    id_ready = 1'b0;
  endtask

  // Random-phase model state
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] pend_addr;
  logic            pending;
  int              pend_cyc;
  int              idle;
  logic            rv;
  logic            redir;
  logic            ef;
  logic [XLEN-1:0] tgt;

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    vt[0] = '{0, 0, 0, 1'b0, XLEN'(32'h8000_0000)};
    vt[1] = '{0, 0, 0, 1'b0, XLEN'(32'h8000_0004)};
    vt[2] = '{0, 0, 0, 1'b0, XLEN'(32'h8000_0008)};
    vt[3] = '{5, 0, 0, 1'b0, XLEN'(32'h8000_000C)};
    vt[4] = '{0, 2, 4, 1'b0, XLEN'(32'h8000_0010)};
    vt[5] = '{1, 1, 1, 1'b1, XLEN'(32'h8000_0014)};
    vt[6] = '{0, 0, 0, 1'b0, XLEN'(32'h8000_0018)};

    step;
    step;
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_req_addr", 64'(imem_req_addr), 64'(RST_PC));
    chk("rst_id_valid", 64'(id_valid), 64'(0));
    chk("rst_id_inst", 64'(id_inst), 64'(0));
    chk("rst_id_pc", 64'(id_pc), 64'(RST_PC));
    chk("rst_id_fault", 64'(id_fault), 64'(0));
    rst = 1'b0;
    chk("boot_req_valid", 64'(imem_req_valid), 64'(0));
    step;
    chk("first_req_valid", 64'(imem_req_valid), 64'(1));

    foreach (vt[i]) run_vec(vt[i]);

    // Redirect while a response is outstanding: that response must vanish.
    chk("pre_redir_addr", 64'(imem_req_addr), 64'(32'h8000_001C));
    imem_req_ready = 1'b1;
    step;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h8000_1000);
    step;
    redirect_valid = 1'b0;
    chk("drop_id_valid", 64'(id_valid), 64'(0));
    chk("drop_req_valid", 64'(imem_req_valid), 64'(0));
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mdata(XLEN'(32'h8000_001C));
    step;
    imem_rsp_valid = 1'b0;
    chk("redir_id_valid", 64'(id_valid), 64'(0));
    chk("redir_req_valid", 64'(imem_req_valid), 64'(1));
    chk("redir_req_addr", 64'(imem_req_addr), 64'(32'h8000_1000));
    run_vec('{0, 0, 0, 1'b0, XLEN'(32'h8000_1000)});

    // Redirect and id_ready together in HOLD: redirect target wins.
    imem_req_ready = 1'b1;
    step;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = mdata(XLEN'(32'h8000_1004));
    step;
    imem_rsp_valid = 1'b0;
    chk("both_id_pc", 64'(id_pc), 64'(32'h8000_1004));
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h8000_3000);
    step;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    chk("both_id_valid", 64'(id_valid), 64'(0));
    chk("both_req_addr", 64'(imem_req_addr), 64'(32'h8000_3000));

    // Redirect in REQ without acceptance, to the top word, then wrap to zero.
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'hFFFF_FFFC);
    step;
    redirect_valid = 1'b0;
    chk("req_redir_valid", 64'(imem_req_valid), 64'(1));
    chk("req_redir_addr", 64'(imem_req_addr), 64'(32'hFFFF_FFFC));
    run_vec('{0, 0, 0, 1'b0, XLEN'(32'hFFFF_FFFC)});
    chk("wrap_req_addr", 64'(imem_req_addr), 64'(0));
    chk("wrap_id_pc", 64'(id_pc), 64'(0));

`ifdef IFU_ALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h8000_0002);
    step;
    redirect_valid = 1'b0;
    chk("align_no_req", 64'(imem_req_valid), 64'(0));
    step;
    chk("align_id_valid", 64'(id_valid), 64'(1));
    chk("align_id_fault", 64'(id_fault), 64'(1));
    chk("align_id_inst", 64'(id_inst), 64'(0));
    chk("align_id_pc", 64'(id_pc), 64'(32'h8000_0002));
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = XLEN'(32'h8000_3000);
    step;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    chk("align_recover_addr", 64'(imem_req_addr), 64'(32'h8000_3000));
`endif

    // Randomized phase: model tracks only the architectural PC stream.
    rst = 1'b1;
    step;
    step;
    rst     = 1'b0;
    exp_pc  = RST_PC;
    pending = 1'b0;
    pend_addr = '0;
    pend_cyc = 0;
    idle    = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rv    = pending && (cyc > pend_cyc) && ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 31) == 0);
      tgt   = XLEN'(32'h8000_0000 + ($urandom_range(0, 63) << 2));
      if ($urandom_range(0, 7) == 0) tgt = tgt + XLEN'($urandom_range(1, 3));
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? mdata(pend_addr) : $urandom;
      imem_rsp_err   = rv ? merr(pend_addr) : 1'($urandom_range(0, 1));
      id_ready       = 1'($urandom_range(0, 1));
      redirect_valid = redir;
      redirect_pc    = tgt;

      if (rv) pending = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        chk("rnd_req_addr", 64'(imem_req_addr), 64'({exp_pc[XLEN-1:2], 2'b00}));
        chk("rnd_single_outstanding", 64'(pending), 64'(0));
        pending   = 1'b1;
        pend_addr = imem_req_addr;
        pend_cyc  = cyc;
      end
      if (id_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
        ef = (exp_pc[1:0] != 2'b00) || merr(exp_pc);
`else
        ef = merr(exp_pc);
`endif
        chk("rnd_id_pc", 64'(id_pc), 64'(exp_pc));
        chk("rnd_id_fault", 64'(id_fault), 64'(ef));
        chk("rnd_id_inst", 64'(id_inst), 64'(ef ? 32'h0 : mdata(exp_pc)));
      end
      if (redir) exp_pc = tgt;
      else if (id_valid && id_ready) exp_pc = exp_pc + XLEN'(4);

      if (id_valid && id_ready) idle = 0;
      else idle++;
      if (idle > 300) begin
        chk("rnd_progress_timeout", 64'(idle), 64'(0));
        break;
      end
      step;
    end
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
